// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// Writes to the hardwired-zero register are accepted but suppressed, and counted.
module regfile_write_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 5,
    parameter int unsigned CW    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_reg,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  wb_stall,
    output logic [AW-1:0]         WriteRegister,
    output logic [WIDTH-1:0]      WriteData,
    output logic                  RegWrite,
    output logic [1:0]            grant_id,
    output logic [CW-1:0]         drop_count
);

    localparam int unsigned GW = 2;
    localparam logic [AW-1:0] ZERO_REG = AW'(31);
    localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

    logic [GW-1:0]    r_ptr;
    logic             w_found;
    logic             w_accept;
    int unsigned      w_idx;
    int unsigned      w_sel;
    logic [NREQ-1:0]  w_vsh;
    logic [GW-1:0]    w_gnt_idx;
    logic [GW-1:0]    w_ptr_nxt;
    logic [AW-1:0]    w_gnt_reg;
    logic [WIDTH-1:0] w_gnt_data;

    // Rotating priority search: first valid requester at or after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 0;
        w_idx   = 0;
        w_vsh   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_vsh = req_valid >> w_idx;
            if (!w_found && w_vsh[0]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_accept   = w_found && reset_n && !wb_stall;
        req_ready  = w_accept ? (NREQ'(1) << w_sel) : '0;
        w_gnt_idx  = GW'(w_sel);
        w_ptr_nxt  = (w_sel + 1 >= NREQ) ? '0 : GW'(w_sel + 1);
        w_gnt_reg  = AW'(req_reg >> (w_sel * AW));
        w_gnt_data = WIDTH'(req_data >> (w_sel * WIDTH));
    end

    // Output stage: a write pulses RegWrite for exactly one cycle; address/data/id hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= '0;
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
            grant_id      <= '0;
            drop_count    <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (w_accept) begin
                r_ptr         <= w_ptr_nxt;
                WriteRegister <= w_gnt_reg;
                WriteData     <= w_gnt_data;
                grant_id      <= w_gnt_idx;
                if (w_gnt_reg == ZERO_REG) begin
                    if (drop_count != DROP_MAX) begin
                        drop_count <= drop_count + CW'(1);
                    end
                end else begin
                    RegWrite <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (WriteRegister/WriteData/RegWrite) between NREQ writeback requesters, e.g. ALU, load unit, and multiply unit.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Write outputs are registered.
- Writes to register 31 (hardwired zero) are accepted, suppressed, and counted.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
NREQ, 3, number of requesters (2..4)
WIDTH, 64, data width
AW, 5, register address width
CW, 8, width of dropped-write counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a write pending
req_ready  output  NREQ  requester i accepted this cycle (combinational)
req_reg  input  NREQ*AW  destination register, slice i = [i*AW +: AW]
req_data  input  NREQ*WIDTH  write data, slice i = [i*WIDTH +: WIDTH]
wb_stall  input  1  blocks all acceptance this cycle
WriteRegister  output  AW  to register file
WriteData  output  WIDTH  to register file
RegWrite  output  1  write enable to register file
grant_id  output  2  index of requester that produced the current output write
drop_count  output  CW  number of accepted writes targeting register 31

Interface decision: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset (reset_n low, async):
  - WriteRegister=0, WriteData=0, RegWrite=0, grant_id=0, drop_count=0, rr pointer=0.
  - req_ready=0 while reset_n is low.
  - A write captured before reset is discarded (RegWrite forced 0 immediately).
- Grant (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit is granted; req_ready is one-hot on that bit.
  - req_ready is all zero if wb_stall=1 or no req_valid is set.
- Acceptance: requester i accepted when req_valid[i] & req_ready[i]. At most one acceptance per cycle.
- Pointer: on acceptance of i, ptr <= (i+1) mod NREQ. With no acceptance, ptr holds.
- Requester rule: req_valid, req_reg and req_data must stay stable until ready. Valid must not drop without acceptance; the bench checks this rule rather than the DUT enforcing it.
- Output stage, at the edge after acceptance of i:
  - WriteRegister <= req_reg[i], WriteData <= req_data[i], grant_id <= i.
  - RegWrite <= 1 if req_reg[i] != 31. If it is 31: RegWrite <= 0 and drop_count increments.
- Without acceptance in a cycle: RegWrite <= 0. WriteRegister, WriteData and grant_id hold their previous values.
- Latency: exactly 1 cycle from accept edge to RegWrite=1. The register file commits at the following edge.
- Throughput: one write per cycle. Back-to-back grants give RegWrite high on consecutive cycles.
- drop_count saturates at 2^CW-1 and never wraps.
- Simultaneous requests to the same register: served in round-robin order, one per cycle. The later-granted write wins in the register file.
- wb_stall rising while a write sits in the output stage does not cancel it: the RegWrite pulse still occurs. Stall only blocks new acceptances.
- Fairness: any requester holding valid is granted within NREQ cycles of non-stalled operation.
- No combinational path from any output of this block back to req_ready other than through req_valid/wb_stall/ptr.

Test Plan:
1. Reset, then requester 0 valid with reg=5, data=0xDEAD_BEEF -> req_ready=001 in cycle 0. Next cycle: RegWrite=1, WriteRegister=5, WriteData=0xDEAD_BEEF, grant_id=0. Following cycle: RegWrite=0.
2. All three requesters held valid continuously (regs 1,2,3) for 6 cycles -> grant order 0,1,2,0,1,2. RegWrite high on 6 consecutive cycles.
3. Requester 1 writes reg=31 data=0xFFFF -> accepted (ready pulses). RegWrite stays 0, drop_count goes 0->1. Repeat 300 times -> drop_count=255.
4. Requesters 0 and 2 valid with wb_stall=1 for 4 cycles -> req_ready=000 and RegWrite=0 throughout. Drop stall -> requester 0 granted first (ptr=0), then requester 2.
5. Requester 2 accepted (reg=7), reset_n pulled low mid-cycle before the RegWrite edge -> RegWrite=0 immediately, all outputs zero. After release, ptr=0, so requesters 0 and 2 both valid -> 0 granted.
6. Requesters 0 and 1 both write reg=9 (0x11, 0x22) in the same cycle -> 0x11 written first, 0x22 on the next cycle. Register-file readback of reg 9 = 0x22.
